rbfu_sched: RTL and testbench
=============================

# rbfu_sched

Sequencing controller for the dual-lane RBFU butterfly unit. It runs a full 256-point, 7-stage Kyber NTT or INTT over a single coefficient RAM. Every cycle it issues two butterflies: four read addresses, two twiddle-ROM addresses and a constant opcode. It delays the read addresses so they come back out as write-back addresses aligned with the RBFU outputs, and it drains the pipeline between stages so that no read-after-write hazard can occur.

## Interface
- `WB_LAT`, default 3: cycles from `rd_en` to the matching `wr_en`. Covers RAM read latency plus RBFU latency. Legal range 1..8.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode`  in  2  2'b00 NTT, 2'b01 INTT; sampled together with `start`
- `busy`  out  1  high from the first issue cycle through the last write-back cycle
- `done`  out  1  one-cycle pulse after the last write-back
- `opcode`  out  2  RBFU opcode, held for the whole run
- `stage`  out  3  current stage, 0..6
- `rd_en`  out  1  read strobe
- `rd_addr0`, `rd_addr1`, `rd_addr2`, `rd_addr3`  out  8 each  addresses of a0, b0, a1, b1
- `tw_addr0`, `tw_addr1`  out  7 each  twiddle ROM index for lane 0 and lane 1
- `wr_en`  out  1  write strobe
- `wr_addr0`, `wr_addr1`, `wr_addr2`, `wr_addr3`  out  8 each  destinations of Dout0, Dout1, Dout2, Dout3
- `hold`  in  1  issue freeze; present only when `RBFU_SCHED_HOLD_EN` is defined

## Operation
- FSM has four states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: moves to ISSUE on `start` with `mode` of 00 or 01. A `start` carrying mode 1x is ignored. The latched mode drives `opcode`.
  - ISSUE: 64 cycles per stage, cycle counter `c` = 0..63, `rd_en` = 1.
  - DRAIN: `WB_LAT` cycles with `rd_en` = 0. Then `stage`+1 and back to ISSUE, or to DONE after stage 6.
  - DONE: one cycle with `done` = 1, then IDLE.
- `start` is ignored outside IDLE.
- Butterfly index: lane 0 uses `bf` = 2c, lane 1 uses `bf` = 2c+1.
  - `len` = 128 >> `stage` for NTT; `len` = 2 << `stage` for INTT.
  - `g` = `bf` / `len`, `j` = 2·`g`·`len` + (`bf` mod `len`).
  - a address = `j`, b address = `j` + `len`.
- Twiddle index: NTT `tw` = 128/`len` + `g`; INTT `tw` = 256/`len` − 1 − `g`.
- All divisions are shifts, since `len` is a power of two. All address arithmetic is unsigned, with 8-bit results for addresses and 7-bit results for twiddle indices.
- Write-back: `rd_en` and `rd_addr0`..`rd_addr3` pass through a `WB_LAT`-deep shift register whose outputs are `wr_en` and `wr_addr0`..`wr_addr3`. Write-back addresses are identical to the read addresses.
- Reset values: every output is 0 and the state is IDLE. An assertion of `rst` mid-run clears the state, the counters and the delay line immediately, so no `wr_en` appears after reset release.

## Timing
- All outputs are registered. `start` sampled at edge 0 gives `rd_en` high at cycle 1.
- Stage `s` issues on cycles 1+s·(64+`WB_LAT`) through 64+s·(64+`WB_LAT`).
- Each write-back lands exactly `WB_LAT` cycles after its read.
- The last write-back is at cycle 448+7·`WB_LAT`. `done` pulses at cycle 449+7·`WB_LAT`, which is cycle 470 with `WB_LAT` = 3.
- `busy` covers cycles 1 through 448+7·`WB_LAT`. It is low while `done` is high.
- Totals per run: 448 `rd_en` cycles and 448 `wr_en` cycles.

## Configuration
- `RBFU_SCHED_HOLD_EN`: when defined, the `hold` port exists.
  - `hold` = 1 in ISSUE forces `rd_en` = 0 and freezes `c`, `stage` and the twiddle indices.
  - The write-back delay line keeps shifting, so in-flight operations still complete.
  - DRAIN begins only after all 64 butterfly pairs of the stage have issued.
- When not defined: no `hold` port, and ISSUE runs unbroken for 64 cycles per stage.

## Test plan
- NTT start, stage 0, first issue cycle → `rd_addr0`..`rd_addr3` = 0, 128, 1, 129; `tw_addr0` = `tw_addr1` = 1; `opcode` = 00.
- NTT stage 6 (`len` = 2), first two issue cycles → addresses 0, 2, 1, 3 with `tw` = 64 both lanes; then 4, 6, 5, 7 with `tw` = 65.
- INTT with `WB_LAT` = 3 → stage 0 first cycle has `tw` = 127; stage 6 has `tw` = 1 throughout. `done` arrives at cycle 470 and exactly 448 `wr_en` cycles are seen, each with write addresses equal to the reads from 3 cycles earlier.
- `start` pulsed while `busy`, and `start` with `mode` = 2'b10 while idle → both ignored; no change to `busy`, `stage` or addresses.
- `rst` low at cycle 100 of an NTT run → all outputs 0 asynchronously; no `wr_en` after release; a new `start` runs cleanly.
- With `RBFU_SCHED_HOLD_EN`, `hold` high for 5 cycles mid-stage-2 → `rd_en` gap of 5 cycles with addresses frozen; `done` delayed by exactly 5 cycles.

Source files
------------

// File: rtl/rbfu_sched.sv
// -----------------------------------------------------------------------------
// rbfu_sched
// Sequencing controller for the dual-lane RBFU butterfly unit. Runs a full
// 256-point, 7-stage Kyber NTT (mode 00) or INTT (mode 01) over a single
// coefficient RAM. Each ISSUE cycle produces two butterflies (four read
// addresses, two twiddle indices). The read strobe and read addresses are
// delayed by WB_LAT cycles to form the write-back strobe and addresses. Each
// stage is followed by a WB_LAT-cycle drain, so a stage never reads a
// coefficient that the previous stage has not yet written back.
//
// Parameters
//   WB_LAT    cycles from rd_en_o to the matching wr_en_o (1..8)
//
// Ports
//   clk_i                rising-edge clock
//   rst_ni               asynchronous active-low reset
//   start_i, mode_i      run request and transform select (sampled in IDLE)
//   hold_i               issue freeze (only with RBFU_SCHED_HOLD_EN defined)
//   busy_o, done_o       run in progress / one-cycle completion pulse
//   opcode_o, stage_o    RBFU opcode (held for the run), current stage 0..6
//   rd_en_o, rd_addr*_o  read strobe; addresses of a0, b0, a1, b1
//   tw_addr0_o/1_o       twiddle ROM index for lane 0 / lane 1
//   wr_en_o, wr_addr*_o  write strobe; destinations of Dout0..Dout3
//
// Optional feature macro: RBFU_SCHED_HOLD_EN (adds hold_i).
// All outputs are registered.
// -----------------------------------------------------------------------------
module rbfu_sched #(
  parameter int unsigned WB_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [1:0] mode_i,
`ifdef RBFU_SCHED_HOLD_EN
  input  logic       hold_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] opcode_o,
  output logic [2:0] stage_o,
  output logic       rd_en_o,
  output logic [7:0] rd_addr0_o,
  output logic [7:0] rd_addr1_o,
  output logic [7:0] rd_addr2_o,
  output logic [7:0] rd_addr3_o,
  output logic [6:0] tw_addr0_o,
  output logic [6:0] tw_addr1_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr0_o,
  output logic [7:0] wr_addr1_o,
  output logic [7:0] wr_addr2_o,
  output logic [7:0] wr_addr3_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] tw;
  } lane_t;

  // One delay-line slot: strobe plus the four addresses (index 0 = a0).
  typedef struct packed {
    logic            en;
    logic [3:0][7:0] addr;
  } wb_t;

  localparam logic [2:0] DRAIN_LAST = 3'(WB_LAT - 1);

  // Butterfly addressing for one lane. len is a power of two, so
  // g = bf/len and j = 2*g*len + bf%len reduce to shifts and a mask.
  // lg is log2(len): 7-stage for NTT (len = 128>>stage), stage+1 for INTT.
  function automatic lane_t lane_calc(input logic [6:0] bf,
                                      input logic [2:0] stg,
                                      input logic       intt);
    logic [2:0] lg;
    logic [7:0] bf8;
    logic [7:0] len;
    logic [7:0] g;
    logic [7:0] j;
    lane_t      r;
    lg   = intt ? stg + 3'd1 : 3'd7 - stg;
    bf8  = {1'b0, bf};
    len  = 8'd1 << lg;
    g    = bf8 >> lg;
    j    = (g << ({1'b0, lg} + 4'd1)) | (bf8 & (len - 8'd1));
    r.a  = j;
    r.b  = j + len;
    // NTT: 128/len + g = (1<<stage) + g ; INTT: 256/len - 1 - g = (128>>stage) - 1 - g
    r.tw = intt ? 7'((8'd128 >> stg) - 8'd1 - g) : 7'((8'd1 << stg) + g);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [5:0] c_q, c_d;
  logic [2:0] stage_q, stage_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [1:0] opcode_q, opcode_d;

  logic hold_w;
`ifdef RBFU_SCHED_HOLD_EN
  assign hold_w = hold_i;
`else
  assign hold_w = 1'b0;
`endif

  // A butterfly pair issues only in ISSUE and only when not frozen.
  logic issue_w;
  assign issue_w = (state_q == S_ISSUE) && !hold_w;

  // FSM process 1: state register (counters are part of the FSM state).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      stage_q  <= '0;
      dcnt_q   <= '0;
      opcode_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of process ordering.
      state_q  <= state_d;
      c_q      <= c_d;
      stage_q  <= stage_d;
      dcnt_q   <= dcnt_d;
      opcode_q <= opcode_d;
    end
  end

  // FSM process 2: next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d  = state_q;
    c_d      = c_q;
    stage_d  = stage_q;
    dcnt_d   = dcnt_q;
    opcode_d = opcode_q;
    unique case (state_q)
      S_IDLE: begin
        // Modes 1x are reserved and ignored.
        if (start_i && !mode_i[1]) begin
          state_d  = S_ISSUE;
          c_d      = '0;
          stage_d  = '0;
          opcode_d = mode_i;
        end
      end
      S_ISSUE: begin
        if (issue_w) begin
          if (c_q == 6'd63) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end else begin
            c_d = c_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          c_d = '0;
          if (stage_q == 3'd6) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM process 3: output logic (next values of the output registers).
  logic  rd_en_d;
  logic  busy_d;
  logic  done_d;
  lane_t lane0_d;
  lane_t lane1_d;

  always_comb begin
    rd_en_d = issue_w;
    busy_d  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done_d  = (state_q == S_DONE);
    lane0_d = lane_calc({c_q, 1'b0}, stage_q, opcode_q[0]);
    lane1_d = lane_calc({c_q, 1'b1}, stage_q, opcode_q[0]);
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic            rd_en_q;
  logic            busy_q;
  logic            done_q;
  logic [2:0]      stage_out_q;
  logic [3:0][7:0] rd_addr_q;
  logic [6:0]      tw0_q;
  logic [6:0]      tw1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_out_q <= '0;
      rd_addr_q   <= '0;
      tw0_q       <= '0;
      tw1_q       <= '0;
    end else begin
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stage_out_q <= stage_q;
      // Addresses only move on an issue, so they hold the last issued
      // pair through drains and hold gaps.
      if (rd_en_d) begin
        rd_addr_q <= {lane1_d.b, lane1_d.a, lane0_d.b, lane0_d.a};
        tw0_q     <= lane0_d.tw;
        tw1_q     <= lane1_d.tw;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back delay line: keeps shifting regardless of hold so in-flight
  // butterflies always complete.
  // ---------------------------------------------------------------------------
  wb_t dl_q [WB_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: this storage array is reset on purpose: a stale strobe left in
      // the line would produce a spurious write after reset release.
      for (int i = 0; i < int'(WB_LAT); i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= '{en: rd_en_q, addr: rd_addr_q};
      for (int i = 1; i < int'(WB_LAT); i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Port assignments
  // ---------------------------------------------------------------------------
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign opcode_o   = opcode_q;
  assign stage_o    = stage_out_q;
  assign rd_en_o    = rd_en_q;
  assign rd_addr0_o = rd_addr_q[0];
  assign rd_addr1_o = rd_addr_q[1];
  assign rd_addr2_o = rd_addr_q[2];
  assign rd_addr3_o = rd_addr_q[3];
  assign tw_addr0_o = tw0_q;
  assign tw_addr1_o = tw1_q;
  assign wr_en_o    = dl_q[WB_LAT-1].en;
  assign wr_addr0_o = dl_q[WB_LAT-1].addr[0];
  assign wr_addr1_o = dl_q[WB_LAT-1].addr[1];
  assign wr_addr2_o = dl_q[WB_LAT-1].addr[2];
  assign wr_addr3_o = dl_q[WB_LAT-1].addr[3];

endmodule

// File: tb/tb_rbfu_sched.sv
// -----------------------------------------------------------------------------
// tb_rbfu_sched
// Self-checking bench for rbfu_sched. A reference model generates every
// expected read (cycle, addresses, twiddles, stage, opcode) when a run is
// started; a monitor pops and compares on each rd_en_o, and forwards the
// expected write-back (same addresses, WB_LAT cycles later) to a second queue
// that is checked on each wr_en_o. Cycle numbers are relative to the edge
// that samples start (edge 0).
// -----------------------------------------------------------------------------
module tb_rbfu_sched;

  localparam int L = 3;
  localparam int LAST_WB = 448 + 7 * L;

  typedef struct {
    logic [31:0] addr;  // {a0, b0, a1, b1}
    logic [18:0] info;  // {tw0, tw1, stage, opcode}
    int          rel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
`ifdef RBFU_SCHED_HOLD_EN
  logic       hold = 1'b0;
`endif
  logic       busy, done, rd_en, wr_en;
  logic [1:0] opcode;
  logic [2:0] stage;
  logic [7:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [7:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic [6:0] tw_addr0, tw_addr1;

  rbfu_sched #(.WB_LAT(L)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .mode_i     (mode),
`ifdef RBFU_SCHED_HOLD_EN
    .hold_i     (hold),
`endif
    .busy_o     (busy),
    .done_o     (done),
    .opcode_o   (opcode),
    .stage_o    (stage),
    .rd_en_o    (rd_en),
    .rd_addr0_o (rd_addr0),
    .rd_addr1_o (rd_addr1),
    .rd_addr2_o (rd_addr2),
    .rd_addr3_o (rd_addr3),
    .tw_addr0_o (tw_addr0),
    .tw_addr1_o (tw_addr1),
    .wr_en_o    (wr_en),
    .wr_addr0_o (wr_addr0),
    .wr_addr1_o (wr_addr1),
    .wr_addr2_o (wr_addr2),
    .wr_addr3_o (wr_addr3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  exp_t        rdq[$];
  exp_t        wrq[$];
  int          t0 = 0;
  bit          run_act = 1'b0;
  logic [1:0]  run_mode = 2'b00;
  int          hold_extra = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_rd_addr = '0;

  function automatic logic [31:0] obs_rd_addr();
    return {rd_addr0, rd_addr1, rd_addr2, rd_addr3};
  endfunction

  function automatic logic [18:0] obs_rd_info();
    return {tw_addr0, tw_addr1, stage, opcode};
  endfunction

  // Reference model written directly from the transform definition
  // (division / modulo on len), independent of the shift form in the RTL.
  task automatic push_model(input logic [1:0] m);
    exp_t e;
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 64; c++) begin
        int len;
        int a [2];
        int b [2];
        int tw [2];
        len = (m == 2'b00) ? (128 >> s) : (2 << s);
        for (int ln = 0; ln < 2; ln++) begin
          int bf, g;
          bf = 2 * c + ln;
          g  = bf / len;
          a[ln]  = 2 * g * len + (bf % len);
          b[ln]  = a[ln] + len;
          tw[ln] = (m == 2'b00) ? (128 / len + g) : (256 / len - 1 - g);
        end
        e.addr = {8'(a[0]), 8'(b[0]), 8'(a[1]), 8'(b[1])};
        e.info = {7'(tw[0]), 7'(tw[1]), 3'(s), m};
        e.rel  = 1 + s * (64 + L) + c;
        rdq.push_back(e);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int   rel;
    exp_t e;
    rel = cyc - t0;
    if (rd_en) begin
      rd_cnt++;
      if (rdq.size() == 0) begin
        check("rd_unexpected", 64'(rd_en), 64'(0));
      end else begin
        e = rdq.pop_front();
        check("rd_cycle", 64'(rel), 64'(e.rel));
        check("rd_addr", 64'(obs_rd_addr()), 64'(e.addr));
        check("rd_info", 64'(obs_rd_info()), 64'(e.info));
        wrq.push_back('{addr: e.addr, info: e.info, rel: e.rel + L});
      end
      last_rd_addr = obs_rd_addr();
      // Directed points from hand-derived constants.
      if (run_act && hold_extra == 0) begin
        if (run_mode == 2'b00 && rel == 1) begin
          check("ntt_s0_addr", 64'(obs_rd_addr()), 64'({8'd0, 8'd128, 8'd1, 8'd129}));
          check("ntt_s0_info", 64'(obs_rd_info()), 64'({7'd1, 7'd1, 3'd0, 2'b00}));
        end
        if (run_mode == 2'b00 && rel == 1 + 6 * (64 + L)) begin
          check("ntt_s6_c0_addr", 64'(obs_rd_addr()), 64'({8'd0, 8'd2, 8'd1, 8'd3}));
          check("ntt_s6_c0_info", 64'(obs_rd_info()), 64'({7'd64, 7'd64, 3'd6, 2'b00}));
        end
        if (run_mode == 2'b00 && rel == 2 + 6 * (64 + L)) begin
          check("ntt_s6_c1_addr", 64'(obs_rd_addr()), 64'({8'd4, 8'd6, 8'd5, 8'd7}));
          check("ntt_s6_c1_info", 64'(obs_rd_info()), 64'({7'd65, 7'd65, 3'd6, 2'b00}));
        end
        if (run_mode == 2'b01 && rel == 1) begin
          check("intt_s0_addr", 64'(obs_rd_addr()), 64'({8'd0, 8'd2, 8'd1, 8'd3}));
          check("intt_s0_info", 64'(obs_rd_info()), 64'({7'd127, 7'd127, 3'd0, 2'b01}));
        end
      end
    end
    if (wr_en) begin
      wr_cnt++;
      if (wrq.size() == 0) begin
        check("wr_unexpected", 64'(wr_en), 64'(0));
      end else begin
        e = wrq.pop_front();
        check("wr_cycle", 64'(rel), 64'(e.rel));
        check("wr_addr", 64'({wr_addr0, wr_addr1, wr_addr2, wr_addr3}), 64'(e.addr));
      end
    end
    if (run_act)
      check("busy", 64'(busy), 64'(rel >= 1 && rel <= LAST_WB + hold_extra));
  end

  task automatic start_run(input logic [1:0] m);
    @(negedge clk);
    #1;
    start      = 1'b1;
    mode       = m;
    t0         = cyc + 1;
    run_mode   = m;
    hold_extra = 0;
    rd_cnt     = 0;
    wr_cnt     = 0;
    push_model(m);
    run_act    = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    mode  = 2'b00;
  endtask

  task automatic wait_rel(input int target);
    for (int i = 0; i < 2000 && (cyc - t0) < target; i++) @(negedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    #1;
    if (!seen) begin
      check("done_timeout", 64'(0), 64'(1));
    end else begin
      check("done_cycle", 64'(cyc - t0), 64'(LAST_WB + 1 + hold_extra));
      check("busy_at_done", 64'(busy), 64'(0));
    end
    run_act = 1'b0;
    @(negedge clk);
    #1;
    check("done_pulse_width", 64'(done), 64'(0));
    check("rd_total", 64'(rd_cnt), 64'(448));
    check("wr_total", 64'(wr_cnt), 64'(448));
    check("rd_queue_left", 64'(rdq.size()), 64'(0));
    check("wr_queue_left", 64'(wrq.size()), 64'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_side"}, 64'({busy, done, opcode, stage, rd_en, obs_rd_addr(), tw_addr0, tw_addr1}), 64'(0));
    check({tag, "_wr_side"}, 64'({wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3}), 64'(0));
  endtask

  initial begin
    #3;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("post_reset");

    // NTT run with a stray start (INTT) while busy.
    start_run(2'b00);
    wait_rel(200);
    start = 1'b1;
    mode  = 2'b01;
    @(negedge clk);
    #1;
    start = 1'b0;
    mode  = 2'b00;
    check("busy_after_stray_start", 64'(busy), 64'(1));
    wait_done();

    // INTT run.
    start_run(2'b01);
    wait_done();

    // Reserved mode while idle is ignored.
    @(negedge clk);
    #1;
    start = 1'b1;
    mode  = 2'b10;
    @(negedge clk);
    #1;
    start = 1'b0;
    mode  = 2'b00;
    repeat (10) @(negedge clk);
    #1;
    check("bad_mode_busy", 64'(busy), 64'(0));
    check("bad_mode_rd_en", 64'(rd_en), 64'(0));
    check("bad_mode_stage", 64'(stage), 64'(0));

    // Asynchronous reset in the middle of an NTT run.
    start_run(2'b00);
    wait_rel(100);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_run_reset");
    run_act = 1'b0;
    rdq.delete();
    wrq.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (20) @(negedge clk);
    #1;
    check("rd_after_reset", 64'(rd_cnt), 64'(0));
    check("wr_after_reset", 64'(wr_cnt), 64'(0));
    check("busy_after_reset", 64'(busy), 64'(0));

    // Clean run after the reset.
    start_run(2'b00);
    wait_done();

`ifdef RBFU_SCHED_HOLD_EN
    // Five-cycle hold in the middle of stage 2.
    start_run(2'b00);
    wait_rel(1 + 2 * (64 + L) + 30);
    hold       = 1'b1;
    hold_extra = 5;
    for (int i = 0; i < rdq.size(); i++) rdq[i].rel += 5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("hold_rd_en", 64'(rd_en), 64'(0));
      check("hold_addr_frozen", 64'(obs_rd_addr()), 64'(last_rd_addr));
    end
    hold = 1'b0;
    wait_done();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
